// File: rtl/rreq_tx.sv
// rtl/rreq_tx.sv - clocked sender for a 4-phase bundled-data request/acknowledge link
// REack is synchronized before use; Rreq and Rdata are driven straight from flops.
module rreq_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             Rreq,
  output logic [WIDTH-1:0] Rdata,
  input  logic             REack,
  output logic             busy,
  output logic [15:0]      xfer_count,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ_HI,
    REQ_LO
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   accept;
  logic                   done;
  logic                   perr_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], REack};
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign in_ready = (state == IDLE) && !ack_s;
  assign busy     = (state != IDLE);
  // An acknowledge before any request has been raised is a receiver fault.
  assign perr_hit = ack_s && ((state == IDLE) || (state == SETUP));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s) begin
          state_nxt = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
    endcase
  end

  // Rreq is registered from the next state so it toggles exactly on state edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      Rreq       <= 1'b0;
      Rdata      <= '0;
      xfer_count <= 16'h0000;
      proto_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      Rreq  <= (state_nxt == REQ_HI);
      if (accept) begin
        Rdata <= in_data;
      end
      if (done) begin
        xfer_count <= xfer_count + 16'd1;
      end
      if (perr_hit) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rreq_tx.sv
// tb/tb_rreq_tx.sv - self-checking bench for rreq_tx
// Transaction-level model checked every cycle plus directed literal expectations.
module tb_rreq_tx;
  localparam int SYNC = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        Rreq;
  logic [7:0]  Rdata;
  logic        REack;
  logic        busy;
  logic [15:0] xfer_count;
  logic        proto_err;

  rreq_tx #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .Rreq(Rreq), .Rdata(Rdata), .REack(REack),
    .busy(busy), .xfer_count(xfer_count), .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Protocol model: where in the handshake we are, and the REack history as seen through the synchronizer.
  int              m_phase;
  logic [SYNC-1:0] m_hist;
  logic            m_rreq;
  logic [7:0]      m_rdata;
  logic [15:0]     m_count;
  logic            m_perr;
  wire             m_ack = m_hist[SYNC-1];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_hist <= '0; m_rreq <= 1'b0;
      m_rdata <= 8'h00; m_count <= 16'h0000; m_perr <= 1'b0;
    end else begin
      m_hist <= {m_hist[SYNC-2:0], REack};
      if (m_ack && m_phase < 2) m_perr <= 1'b1;
      case (m_phase)
        0: if (in_valid && !m_ack) begin m_rdata <= in_data; m_phase <= 1; end
        1: begin m_phase <= 2; m_rreq <= 1'b1; end
        2: if (m_ack) begin m_phase <= 3; m_rreq <= 1'b0; end
        default: if (!m_ack) begin m_phase <= 0; m_count <= m_count + 16'd1; end
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc_rreq", Rreq, m_rreq);
    check("cyc_rdata", Rdata, m_rdata);
    check("cyc_busy", busy, m_phase != 0);
    check("cyc_in_ready", in_ready, (m_phase == 0) && !m_ack);
    check("cyc_xfer_count", xfer_count, m_count);
    check("cyc_proto_err", proto_err, m_perr);
  end

  // Receiver: follows Rreq after a programmable number of clocks.
  logic auto_rx = 1'b1;
  int   dly_hi = 0;
  int   dly_lo = 0;
  int   rx_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (auto_rx) begin
      if (Rreq != REack) begin
        if (rx_cnt >= (Rreq ? dly_hi : dly_lo)) begin
          REack = Rreq;
          rx_cnt = 0;
        end else begin
          rx_cnt++;
        end
      end else begin
        rx_cnt = 0;
      end
    end
  end

  logic [7:0] seen[$];
  logic       prev_rreq = 1'b0;
  always @(negedge clk) begin
    if (Rreq && !prev_rreq) seen.push_back(Rdata);
    prev_rreq = Rreq;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin step(); n++; end
    check(name, n < budget, 1'b1);
  endtask

  task automatic rst_pulse();
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    check("rst_release_in_ready", in_ready, 1'b1);
  endtask

  task automatic xfer(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_idle("xfer_timeout", 3000);
  endtask

  int  n;
  int  idx;
  logic r;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; REack = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_rreq", Rreq, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", xfer_count, 16'h0000);
    check("rst_perr", proto_err, 1'b0);
    check("rst_rdata", Rdata, 8'h00);
    step(); step();
    rst = 1'b1;
    check("first_cycle_in_ready", in_ready, 1'b1);

    // Single transfer, receiver 3/3 clocks
    dly_hi = 3; dly_lo = 3;
    step();
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 8'h3C;
    check("t1_rdata_loaded", Rdata, 8'hA5);
    check("t1_rreq_still_low", Rreq, 1'b0);
    step();
    check("t1_rreq_rise", Rreq, 1'b1);
    n = 0;
    while (!REack && n < 50) begin step(); n++; end
    check("t1_ack_timeout", n < 50, 1'b1);
    n = 0;
    while (Rreq && n < 20) begin step(); n++; end
    check("t1_edges_ack_to_rreq_low", n, SYNC + 1);
    wait_idle("t1_idle_timeout", 100);
    check("t1_count", xfer_count, 16'd1);
    check("t1_in_ready", in_ready, 1'b1);
    check("t1_rdata_held", Rdata, 8'hA5);

    // Back-to-back, zero-delay receiver
    rst_pulse();
    dly_hi = 0; dly_lo = 0;
    seen.delete();
    idx = 0; in_data = 8'h01; in_valid = 1'b1; n = 0;
    while (idx < 5 && n < 300) begin
      r = in_ready;
      step(); n++;
      if (r) begin idx++; in_data = 8'(idx + 1); end
    end
    in_valid = 1'b0;
    check("t2_feed", idx, 5);
    wait_idle("t2_idle_timeout", 100);
    check("t2_seen_n", seen.size(), 5);
    for (int i = 0; i < 5; i++) check("t2_order", (i < seen.size()) ? seen[i] : 8'hxx, 8'(i + 1));
    check("t2_count", xfer_count, 16'd5);

    // Reset while the request is high
    rst_pulse();
    dly_hi = 20; dly_lo = 2;
    step();
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!Rreq && n < 10) begin step(); n++; end
    check("t3_rreq_timeout", n < 10, 1'b1);
    step(); step();
    rst = 1'b0;
    #1;
    check("t3_rreq_async", Rreq, 1'b0);
    check("t3_busy_async", busy, 1'b0);
    check("t3_count_async", xfer_count, 16'd0);
    step();
    rst = 1'b1;
    xfer(8'hC3);
    check("t3_next_count", xfer_count, 16'd1);
    check("t3_next_rdata", Rdata, 8'hC3);

    // Slow receiver: Rreq stays up for the whole delay
    dly_hi = 1000; dly_lo = 1;
    step();
    in_data = 8'h96; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!Rreq && n < 10) begin step(); n++; end
    check("t4_rreq_timeout", n < 10, 1'b1);
    n = 0; r = 1'b1;
    while (Rreq && n < 2000) begin
      r = r & busy;
      n++;
      step();
    end
    check("t4_rreq_high_cycles", n, 1003);
    check("t4_busy_held", r, 1'b1);
    wait_idle("t4_idle_timeout", 100);
    check("t4_count", xfer_count, 16'd2);

    // Counter wrap
    dly_hi = 1; dly_lo = 1;
    step();
    force dut.xfer_count = 16'hFFFF;
    m_count = 16'hFFFF;
    step();
    release dut.xfer_count;
    check("t5_preload", xfer_count, 16'hFFFF);
    xfer(8'h11);
    check("t5_wrap", xfer_count, 16'h0000);
    check("t5_no_perr", proto_err, 1'b0);

    // Acknowledge while idle
    auto_rx = 1'b0;
    REack = 1'b0;
    step();
    REack = 1'b1;
    n = 0;
    while (!proto_err && n < 20) begin step(); n++; end
    check("t6_edges_to_perr", n, SYNC + 1);
    check("t6_in_ready_low", in_ready, 1'b0);
    in_data = 8'h77; in_valid = 1'b1;
    repeat (5) step();
    check("t6_no_accept", busy, 1'b0);
    in_valid = 1'b0;
    REack = 1'b0;
    repeat (SYNC + 1) step();
    check("t6_in_ready_back", in_ready, 1'b1);
    check("t6_perr_sticky", proto_err, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_perr_cleared", proto_err, 1'b0);
    step();
    rst = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
